// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a common-anode 7-segment bank.
// Latency: 1 clk from count/idx/inputs to the registered seg/dp_out/an pins.
// Backpressure: none; free-running scan, inputs sampled live every cycle.
//
// Ports: clk, rst (sync, active-high); digits (4 bits per digit, digit 0 in LSBs);
//        blank/dp (per-digit); brightness (duty select); seg/dp_out/an (active-low).
// Optional: define SEVEN_SEG_SCANNER_BLINK_EN to add the per-digit blink input
//           and the frame counter that drives the blink phase.
module seven_seg_scanner #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_W      = 17,
    parameter int BRIGHT_W   = 3,
    parameter int BLINK_W    = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [NUM_DIGITS-1:0]   dp,
`ifdef SEVEN_SEG_SCANNER_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink,
`endif
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // Elaboration-time parameter sanity checks.
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
        $error("seven_seg_scanner: NUM_DIGITS must be 1..16");
    end
    if (BRIGHT_W < 1 || BRIGHT_W > DIV_W) begin : g_bad_bright
        $error("seven_seg_scanner: BRIGHT_W must be 1..DIV_W");
    end
    if (BLINK_W < 1) begin : g_bad_blink
        $error("seven_seg_scanner: BLINK_W must be >= 1");
    end

    // Active-low {g,f,e,d,c,b,a} hex decode.
    function automatic logic [6:0] hex_decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [DIV_W-1:0]      count_q, count_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  slot_end;
    logic                  en;
    logic                  lit;
    logic [NUM_DIGITS-1:0] dark;
    logic [3:0]            cur_digit;
    logic                  cur_dark;
    logic                  cur_dp;

    assign slot_end = &count_q;

    // The lit window is the first (brightness+1)/2^BRIGHT_W of each slot,
    // so it always begins at count=0.
    assign en = (count_q[DIV_W-1 -: BRIGHT_W] <= brightness);

`ifdef SEVEN_SEG_SCANNER_BLINK_EN
    logic [BLINK_W-1:0] frame_q, frame_d;

    // One frame = one full pass over all digits.
    assign frame_d = (slot_end && idx_q == LAST_IDX) ? frame_q + 1'b1 : frame_q;
    assign dark    = blank | (blink & {NUM_DIGITS{frame_q[BLINK_W-1]}});

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end
`else
    assign dark = blank;
`endif

    assign count_d = count_q + 1'b1;
    assign idx_d   = !slot_end          ? idx_q :
                     (idx_q == LAST_IDX) ? '0    : idx_q + 1'b1;

    // Mux the current digit's fields; a loop avoids multiplying idx for the slice.
    always_comb begin
        cur_digit = 4'h0;
        cur_dark  = 1'b1;
        cur_dp    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = digits[4*i +: 4];
                cur_dark  = dark[i];
                cur_dp    = dp[i];
            end
        end
    end

    assign lit = en && !cur_dark;

    // Anode pattern is derived from a single idx, so at most one bit is ever low.
    always_comb begin
        an_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (lit && idx_q == IDX_W'(i)) begin
                an_d[i] = 1'b0;
            end
        end
        seg_d = lit ? hex_decode(cur_digit) : 7'h7F;
        dp_d  = lit ? !cur_dp : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            count_q <= count_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an     = an_q;
    assign seg    = seg_q;
    assign dp_out = dp_q;

endmodule
